// File: rtl/serial_digit_adder.sv
// serial_digit_adder: adds two WIDTH-bit operands plus carry-in over
// NDIG = WIDTH/DIGIT clock cycles. Each cycle one DIGIT-bit ripple slice
// is used, least significant digit first. Sum/Cout change only on the
// edge that raises done, and then hold until the next operation completes.
//
// Optional feature: define SERIAL_DIGIT_ADDER_SUB_EN to add the Sub input.
// With Sub=1 the block computes A - B - Cin, and Cout is an active-low
// borrow (1 = no borrow).
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   operation request, sampled only while idle
//   A, B   in   WIDTH-bit operands, captured on the accepting edge
//   Cin    in   carry-in, captured on the accepting edge
//   Sub    in   subtract select (only with SERIAL_DIGIT_ADDER_SUB_EN)
//   busy   out  high while digits are being processed
//   done   out  one-cycle pulse, Sum/Cout just updated
//   Sum    out  WIDTH-bit result of last completed operation
//   Cout   out  carry-out of last completed operation
module serial_digit_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  // Operand conditioning at capture time: subtraction is A + ~B + ~Cin.
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
  assign b_in   = Sub ? ~B : B;
  assign cin_in = Sub ? ~Cin : Cin;
`else
  assign b_in   = B;
  assign cin_in = Cin;
`endif

  // DIGIT-bit ripple slice on the low digit of the shifting operand registers.
  logic [DIGIT-1:0] slice_s;
  logic             slice_c;
  logic             rc;
  always_comb begin
    rc      = carry_q;
    slice_s = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      slice_s[i] = a_q[i] ^ b_q[i] ^ rc;
      rc         = (a_q[i] & b_q[i]) | (rc & (a_q[i] ^ b_q[i]));
    end
    slice_c = rc;
  end

  // Partial result fills from the top so the final digit lands LSB-aligned.
  logic [WIDTH-1:0] part_next;
  assign part_next = (part_q >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));

  logic last_digit;
  assign last_digit = (cnt_q == CW'(NDIG - 1));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      part_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    part_d  = part_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = b_in;
          carry_d = cin_in;
          part_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = slice_c;
        part_d  = part_next;
        cnt_d   = cnt_q + CW'(1);
        if (last_digit) begin
          state_d = IDLE;
          sum_d   = part_next;
          cout_d  = slice_c;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Scoreboard bench for serial_digit_adder: the driver predicts acceptance
// and pushes expected results; the negedge monitor checks busy/done timing
// and the held Sum/Cout values every cycle.
module tb_serial_digit_adder;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] Sum;
  logic        Cout;

  int   total;
  int   bad;
  int   cyc;
  int   next_free;
  bit   mon_en;
  exp_t q[$];
  logic [15:0] model_sum;
  logic        model_cout;

  serial_digit_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    .Sub  (sub),
`endif
    .busy (busy),
    .done (done),
    .Sum  (Sum),
    .Cout (Cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Plain-arithmetic reference: {carry/no-borrow, result}.
  function automatic logic [16:0] ref_model(logic [15:0] a, logic [15:0] b,
                                            logic ci, logic sb);
    int r;
    if (sb) begin
      r = int'(a) - int'(b) - int'(ci);
      return {(r >= 0) ? 1'b1 : 1'b0, r[15:0]};
    end
    r = int'(a) + int'(b) + int'(ci);
    return r[16:0];
  endfunction

  // One cycle of stimulus; predicts whether the next edge accepts start.
  task automatic drive(input logic st, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sb, input logic r);
    int          e;
    logic        sb_eff;
    logic [16:0] res;
    exp_t        ent;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    sb_eff = sb;
`else
    sb_eff = 1'b0;
`endif
    e     = cyc + 1;
    rst   = r;
    start = st;
    A     = a;
    B     = b;
    Cin   = ci;
    sub   = sb_eff;
    if (r) begin
      next_free = e + 1;
    end else if (st && e >= next_free) begin
      res      = ref_model(a, b, ci, sb_eff);
      ent.sum  = res[15:0];
      ent.cout = res[16];
      ent.cyc  = e + NDIG;
      q.push_back(ent);
      next_free = e + NDIG + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                    input logic sb);
    drive(1'b1, a, b, ci, sb, 1'b0);
    idle(NDIG + 1);
  endtask

  // Monitor: busy/done timing from the queue head, Sum/Cout against last result.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_busy;
      logic exp_done;
      exp_done = (q.size() > 0) && (q[0].cyc == cyc);
      exp_busy = (q.size() > 0) && (cyc >= q[0].cyc - NDIG) && (cyc < q[0].cyc);
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        model_sum  = q[0].sum;
        model_cout = q[0].cout;
        void'(q.pop_front());
      end
      check("sum", 32'(Sum), 32'(model_sum));
      check("cout", 32'(Cout), 32'(model_cout));
      if (rst) begin
        q.delete();
        model_sum  = 16'h0;
        model_cout = 1'b0;
      end
    end
  end

  initial begin
    total      = 0;
    bad        = 0;
    cyc        = 0;
    next_free  = 0;
    mon_en     = 1'b0;
    model_sum  = 16'h0;
    model_cout = 1'b0;
    rst   = 1'b1;
    start = 1'b1;
    A     = 16'hABCD;
    B     = 16'h1234;
    Cin   = 1'b1;
    sub   = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    // Reset held with start high, then released.
    drive(1'b1, 16'hABCD, 16'h1234, 1'b1, 1'b0, 1'b1);
    idle(3);

    // Basic add and carry ripple cases.
    op(16'h1234, 16'h4321, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    op(16'h8000, 16'h8000, 1'b0, 1'b0);

    // start during 2nd busy cycle is ignored.
    drive(1'b1, 16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    idle(NDIG);

    // start held through the done cycle: back-to-back acceptance.
    drive(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NDIG + 1; i++) drive(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    idle(NDIG + 2);

    // Abort mid-operation: no done, outputs cleared.
    drive(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b1);
    idle(10);

`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    op(16'h0005, 16'h0007, 1'b0, 1'b1);
    op(16'h0007, 16'h0005, 1'b1, 1'b1);
`endif

    // Random traffic: pulsed/held starts, occasional resets.
    for (int i = 0; i < 600; i++) begin
      int rr;
      rr = int'($urandom_range(99));
      if (rr < 3) drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      else drive(rr < 55, 16'($urandom), 16'($urandom), 1'($urandom_range(1)),
                 1'($urandom_range(1)), 1'b0);
    end
    idle(NDIG + 3);
    check("drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
